// File: rtl/ex_mdu_pkg.sv
// Shared MDU definitions: opcode encodings, FSM state encoding and reset polarity.
package ex_mdu_pkg;

  // Reset is active-low
  localparam logic RST_ACTIVE = 1'b0;

  // MDU opcodes carried on op_i
  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // True for the ops that run on the iterative datapath
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// One radix-2 iteration shared by the shift-add multiplier and the restoring divider.
module ex_mdu_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              div_mode,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] nxt_hi,
  output logic [DATA_W-1:0] nxt_lo
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] r_sh;
  logic [DATA_W:0] diff;

  // Multiply: conditional add then shift right; divide: shift in dividend MSB, trial subtract
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
    r_sh = {acc_hi, acc_lo[DATA_W-1]};
    diff = r_sh - {1'b0, divisor};
    if (div_mode) begin
      // Partial remainder stays below the divisor, so bit DATA_W of diff is the borrow
      if (!diff[DATA_W]) begin
        nxt_hi = diff[DATA_W-1:0];
        nxt_lo = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        nxt_hi = r_sh[DATA_W-1:0];
        nxt_lo = {acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[DATA_W:1];
      nxt_lo = {sum[0], acc_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit owning HI/LO; stalls the pipeline while an op is in flight.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              cancel_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] acc_hi_q, acc_lo_q, bmag_q;
  logic              done_q, dz_q;
  logic              div_q, dzero_q;
  logic              neg_lo_q;  // product / quotient sign
  logic              neg_hi_q;  // remainder sign

  logic              op_signed, op_div, op_muldiv, opb_zero, accept;
  logic [DATA_W-1:0] amag, bmag;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] quot_fix, rem_fix;
  logic [2*DATA_W-1:0] prod, prod_fix;

  // Opcode decode and operand magnitudes for capture on the accept edge
  always_comb begin
    op_muldiv = is_muldiv(op_i);
    op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    op_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    opb_zero  = (opb_i == '0);
    amag      = (op_signed && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    bmag      = (op_signed && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    accept    = start_i && !cancel_i && (state_q == MDU_IDLE);
  end

  // Sign correction applied in FIX
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_lo_q ? -prod : prod;
    quot_fix = neg_lo_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;
  end

  ex_mdu_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .div_mode(div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .divisor (bmag_q),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  // Control FSM with datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      bmag_q   <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      div_q    <= 1'b0;
      dzero_q  <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            case (op_i)
              MDU_MTHI: hi_q <= opa_i;
              MDU_MTLO: lo_q <= opa_i;
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                div_q    <= op_div;
                dzero_q  <= op_div && opb_zero;
                // A zero divisor parks the raw dividend here for HI
                acc_hi_q <= (op_div && opb_zero) ? opa_i : '0;
                acc_lo_q <= amag;
                bmag_q   <= bmag;
                neg_lo_q <= op_signed && (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
                neg_hi_q <= op_signed && opa_i[DATA_W-1];
                cnt_q    <= CNT_W'(DATA_W - 1);
                state_q  <= (op_div && opb_zero) ? MDU_FIX : MDU_CALC;
              end
              default: ;
            endcase
          end
        end
        MDU_CALC: begin
          if (cancel_i) begin
            state_q <= MDU_IDLE;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q == '0) begin
              state_q <= MDU_FIX;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        MDU_FIX: begin
          state_q <= MDU_IDLE;
          if (!cancel_i) begin
            done_q <= 1'b1;
            if (dzero_q) begin
              hi_q <= acc_hi_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
              dz_q <= 1'b0;
            end else begin
              hi_q <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle of an iterative op and the whole time it is in flight
  always_comb begin
    busy_o  = (state_q != MDU_IDLE);
    stall_o = busy_o || (start_i && op_muldiv && (state_q == MDU_IDLE));
    done_o  = done_q;
    dz_o    = dz_q;
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: 32-bit instance plus an 8-bit instance.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk, rst;
  logic        start, cancel;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        stall, busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, cancel8;
  logic [2:0]  op8;
  logic [7:0]  opa8, opb8;
  logic        stall8, busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  exp_t sb_q[$];
  exp_t sb8_q[$];
  int   checks, errors;
  logic m_dz, m_dz8;

  ex_mdu #(.DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .cancel_i(cancel), .stall_o(stall), .busy_o(busy), .done_o(done), .dz_o(dz),
    .hi_o(hi), .lo_o(lo)
  );

  ex_mdu #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .opa_i(opa8), .opb_i(opb8),
    .cancel_i(cancel8), .stall_o(stall8), .busy_o(busy8), .done_o(done8), .dz_o(dz8),
    .hi_o(hi8), .lo_o(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit arithmetic on w-bit operands
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int w, input logic dz_prev);
    exp_t e;
    logic [63:0] mask, ua, ub, pb;
    longint sa, sb, q, r;
    logic sgn;
    mask = (64'd1 << w) - 64'd1;
    sgn  = (o == MDU_MULT) || (o == MDU_DIV);
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    if (sgn && ua[w-1]) ua = ua | ~mask;
    if (sgn && ub[w-1]) ub = ub | ~mask;
    e.dz  = dz_prev;
    e.lat = w + 1;
    if (o == MDU_MULT || o == MDU_MULTU) begin
      pb   = ua * ub;
      e.hi = 32'((pb >> w) & mask);
      e.lo = 32'(pb & mask);
    end else if ((ub & mask) == 64'd0) begin
      e.lo  = 32'(mask);
      e.hi  = 32'({32'd0, a} & mask);
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      sa   = longint'(ua);
      sb   = longint'(ub);
      q    = sa / sb;
      r    = sa % sb;
      e.lo = 32'(64'(q) & mask);
      e.hi = 32'(64'(r) & mask);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input bit push, output logic st, output logic dn);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    #1;
    st = stall;
    dn = done;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; op = MDU_NOP;
  endtask

  task automatic wait_done(output int cyc, output logic held);
    cyc  = 0;
    held = 1'b1;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (!stall) held = 1'b0;
    end
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e);
    @(negedge clk);
    start8 = 1'b1; op8 = o; opa8 = a; opb8 = b;
    sb8_q.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = MDU_NOP;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done8) break;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", dz); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [7] = '{MDU_MULTU, MDU_MULT, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU, MDU_DIVU};
    logic [31:0] t_a [7] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                             32'd5, 32'd6};
    logic [31:0] t_b [7] = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd3};
    logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5, 32'd0};
    logic [31:0] t_lo [7] = '{32'h1, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000,
                              32'hFFFFFFFF, 32'd2};
    logic        t_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e, g;
    logic st, dn, held;
    int   cyc;
    for (int i = 0; i < 7; i++) begin
      e.hi = t_hi[i]; e.lo = t_lo[i]; e.dz = t_dz[i];
      e.lat = (t_b[i] == 32'd0) ? 1 : 33;
      issue(t_op[i], t_a[i], t_b[i], e, 1'b1, st, dn);
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL dir%0d_issue_stall got=%b want=1", i, st); end
      wait_done(cyc, held);
      g = sb_q.pop_front();
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL dir%0d_stall_held got=%b want=1", i, held); end
      checks++; if (cyc != g.lat) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, g.lat); end
      checks++; if (hi !== g.hi) begin errors++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, g.hi); end
      checks++; if (lo !== g.lo) begin errors++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, g.lo); end
      checks++; if (dz !== g.dz) begin errors++; $display("FAIL dir%0d_dz got=%b want=%b", i, dz, g.dz); end
    end
    m_dz = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    logic st, dn, held;
    int   cyc;
    e.hi = 32'd0; e.lo = 32'd100; e.dz = m_dz; e.lat = 33;
    issue(MDU_MULTU, 32'd10, 32'd10, e, 1'b1, st, dn);
    wait_done(cyc, held);
    g = sb_q.pop_front();
    checks++; if (lo !== g.lo) begin errors++; $display("FAIL b2b_first_lo got=%h want=%h", lo, g.lo); end
    e.hi = 32'd0; e.lo = 32'd6; e.dz = m_dz; e.lat = 33;
    issue(MDU_MULT, 32'd2, 32'd3, e, 1'b1, st, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL b2b_issue_in_done got=%b want=1", dn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accepted got=%b want=1", busy); end
    wait_done(cyc, held);
    g = sb_q.pop_front();
    checks++; if (cyc != g.lat) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, g.lat); end
    checks++; if (hi !== g.hi) begin errors++; $display("FAIL b2b_hi got=%h want=%h", hi, g.hi); end
    checks++; if (lo !== g.lo) begin errors++; $display("FAIL b2b_lo got=%h want=%h", lo, g.lo); end
  endtask

  task automatic test_mt();
    exp_t e;
    logic st1, st2, dn;
    e.hi = 32'd0; e.lo = 32'd0; e.dz = 1'b0; e.lat = 0;
    issue(MDU_MTHI, 32'h1234, 32'd0, e, 1'b0, st1, dn);
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_zero_latency got=%h want=1234", hi); end
    issue(MDU_MTLO, 32'hABCD, 32'd0, e, 1'b0, st2, dn);
    checks++; if (st1 !== 1'b0 || st2 !== 1'b0) begin errors++; $display("FAIL mt_stall got=%b%b want=00", st1, st2); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mt_hi got=%h want=1234", hi); end
    checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mt_lo got=%h want=abcd", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mt_idle busy=%b done=%b want=0 0", busy, done); end
  endtask

  task automatic test_cancel();
    exp_t e;
    logic st, dn;
    int   seen;
    e.hi = 32'd0; e.lo = 32'd0; e.dz = 1'b0; e.lat = 0;
    issue(MDU_DIVU, 32'd1000, 32'd3, e, 1'b0, st, dn);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle busy got=%b want=0", busy); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL cancel_no_done got=%0d want=0", seen); end
    checks++; if (hi !== 32'h1234 || lo !== 32'hABCD) begin errors++; $display("FAIL cancel_hilo got=%h/%h want=1234/abcd", hi, lo); end
    // Cancel and start together: nothing accepted
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; opa = 32'd2; opb = 32'd3; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0; op = MDU_NOP;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy got=%b want=0", busy); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0 || lo !== 32'hABCD) begin errors++; $display("FAIL cancel_start_result done=%0d lo=%h want=0 abcd", seen, lo); end
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    logic st, dn, held;
    int   cyc;
    e.hi = 32'd9; e.lo = 32'hFFFFFFFF; e.dz = 1'b1; e.lat = 1;
    issue(MDU_DIVU, 32'd9, 32'd0, e, 1'b1, st, dn);
    wait_done(cyc, held);
    g = sb_q.pop_front();
    checks++; if (cyc != g.lat) begin errors++; $display("FAIL dz_latency got=%0d want=%0d", cyc, g.lat); end
    checks++; if (dz !== g.dz || lo !== g.lo || hi !== g.hi) begin errors++; $display("FAIL dz_result got=%b %h %h want=%b %h %h", dz, hi, lo, g.dz, g.hi, g.lo); end
    issue(MDU_MULT, 32'd5, 32'd5, e, 1'b0, st, dn);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got=%h/%h want=0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b/%b want=0/0", busy, stall); end
    checks++; if (dz !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b want=0/0", dz, done); end
    @(negedge clk);
    rst  = 1'b1;
    m_dz = 1'b0;
  endtask

  task automatic test_random();
    exp_t e, g;
    logic st, dn, held;
    int   cyc;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i == 3) begin o = MDU_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
      e = model(o, a, b, 32, m_dz);
      m_dz = e.dz;
      issue(o, a, b, e, 1'b1, st, dn);
      wait_done(cyc, held);
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL rnd%0d_queue got=empty want=entry", i);
      end else begin
        g = sb_q.pop_front();
        checks++; if (cyc != g.lat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, o, cyc, g.lat); end
        checks++; if (hi !== g.hi || lo !== g.lo) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, o, a, b, hi, lo, g.hi, g.lo); end
        checks++; if (dz !== g.dz) begin errors++; $display("FAIL rnd%0d_dz got=%b want=%b", i, dz, g.dz); end
      end
    end
  endtask

  task automatic test_w8();
    exp_t e, g;
    int   cyc;
    logic [2:0] o;
    logic [7:0] a, b;
    e.hi = 32'h40; e.lo = 32'h00; e.dz = 1'b0; e.lat = 9;
    issue8(MDU_MULT, 8'h80, 8'h80, e);
    wait_done8(cyc);
    g = sb8_q.pop_front();
    checks++; if (cyc != g.lat) begin errors++; $display("FAIL w8_mult_latency got=%0d want=%0d", cyc, g.lat); end
    checks++; if (hi8 !== g.hi[7:0] || lo8 !== g.lo[7:0]) begin errors++; $display("FAIL w8_mult got=%h_%h want=%h_%h", hi8, lo8, g.hi[7:0], g.lo[7:0]); end
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(1, 4));
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      e = model(o, {24'd0, a}, {24'd0, b}, 8, m_dz8);
      m_dz8 = e.dz;
      issue8(o, a, b, e);
      wait_done8(cyc);
      g = sb8_q.pop_front();
      checks++; if (cyc != g.lat) begin errors++; $display("FAIL w8_rnd%0d_latency got=%0d want=%0d", i, cyc, g.lat); end
      checks++; if (hi8 !== g.hi[7:0] || lo8 !== g.lo[7:0] || dz8 !== g.dz) begin errors++; $display("FAIL w8_rnd%0d op=%0d a=%h b=%h got=%h_%h dz=%b want=%h_%h dz=%b", i, o, a, b, hi8, lo8, dz8, g.hi[7:0], g.lo[7:0], g.dz); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; m_dz = 1'b0; m_dz8 = 1'b0;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = MDU_NOP; opa = '0; opb = '0;
    start8 = 1'b0; cancel8 = 1'b0; op8 = MDU_NOP; opa8 = '0; opb8 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mt();
    test_cancel();
    test_reset_mid();
    test_random();
    test_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
